kbd_hid_decode: RTL

Converts 8-byte HID boot-protocol keyboard reports (BLE keyboard, forwarded by the ESP32 over the SPI link) into a byte stream of make/break key events. Sits directly upstream of the keyboard Wishbone peripheral: `evt_data`/`evt_stb` drive its `kbd_rx_data`/`kbd_rx_stb`. The downstream has no backpressure, so this block owns all pacing and buffering.

---
 rtl/kbd_hid_pkg.sv | 86 ++++++++
 rtl/kbd_hid_rpt_cap.sv | 53 +++++
 rtl/kbd_hid_decode.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/kbd_hid_pkg.sv
// Shared constants, types and slot helpers for the HID boot-report keyboard decoder.
// Used by kbd_hid_rpt_cap and kbd_hid_decode.
package kbd_hid_pkg;

    localparam int RPT_LEN = 8;
    localparam int N_SLOTS = RPT_LEN - 2;

    localparam logic [7:0] BRK_PREFIX  = 8'hF0;
    localparam logic [7:0] MOD_BASE    = 8'hE0;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;
    localparam logic [7:0] KC_NONE     = 8'h00;

    // Byte 0 = modifiers, byte 1 = reserved, bytes 2..7 = keycode slots.
    typedef logic [RPT_LEN-1:0][7:0] rpt_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MOD      = 3'd1,
        ST_BRK      = 3'd2,
        ST_BRK_CODE = 3'd3,
        ST_MAKE     = 3'd4,
        ST_DONE     = 3'd5
    } eng_state_t;

    typedef struct packed {
        eng_state_t st;
        logic [2:0] idx;
    } step_t;

    function automatic logic [7:0] slot_code(rpt_t r, logic [2:0] j);
        logic [2:0] s;
        s = j + 3'd2;
        return r[s];
    endfunction

    function automatic logic in_slots(rpt_t r, logic [7:0] kc);
        logic hit;
        hit = 1'b0;
        for (int m = 0; m < N_SLOTS; m++) begin
            if (slot_code(r, 3'(m)) == kc) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when kc already appears in a slot below j, so only its first occurrence reports.
    function automatic logic dup_below(rpt_t r, logic [2:0] j, logic [7:0] kc);
        logic hit;
        hit = 1'b0;
        for (int m = 0; m < N_SLOTS; m++) begin
            if ((3'(m) < j) && (slot_code(r, 3'(m)) == kc)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic step_t step_after(eng_state_t st, logic [2:0] idx);
        step_t s;
        s.st  = st;
        s.idx = idx + 3'd1;
        case (st)
            ST_MOD: begin
                if (idx == 3'd7) begin
                    s.st  = ST_BRK;
                    s.idx = 3'd0;
                end
            end
            ST_BRK: begin
                if (idx == 3'(N_SLOTS - 1)) begin
                    s.st  = ST_MAKE;
                    s.idx = 3'd0;
                end
            end
            ST_MAKE: begin
                if (idx == 3'(N_SLOTS - 1)) begin
                    s.st  = ST_DONE;
                    s.idx = 3'd0;
                end
            end
            default: begin
                s.st  = ST_IDLE;
                s.idx = 3'd0;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kbd_hid_rpt_cap.sv
// Report capture: byte counter, capture buffer, pending flag and drop/error pulses.
// The buffer is stable whenever pending is set; take clears pending in the same cycle it is read.
module kbd_hid_rpt_cap
    import kbd_hid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rpt_data,
    input  logic       rpt_first,
    input  logic       rpt_stb,
    input  logic       take,
    output rpt_t       rpt_buf,
    output logic       pending,
    output logic       rpt_drop,
    output logic       rpt_err
);

    localparam logic [3:0] CNT_FULL = 4'(RPT_LEN);
    localparam logic [3:0] CNT_LAST = 4'(RPT_LEN - 1);

    // Bytes stored in the current report: 0 = no capture open, CNT_FULL = complete.
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            rpt_buf  <= '0;
            pending  <= 1'b0;
            rpt_drop <= 1'b0;
            rpt_err  <= 1'b0;
        end else begin
            rpt_drop <= 1'b0;
            rpt_err  <= 1'b0;
            if (take) pending <= 1'b0;

            if (rpt_stb && rpt_first) begin
                rpt_buf[0] <= rpt_data;
                cnt        <= 4'd1;
                if (cnt != 4'd0 && cnt != CNT_FULL) rpt_err <= 1'b1;
                if (pending && !take) rpt_drop <= 1'b1;
                pending    <= 1'b0;
            end else if (rpt_stb && cnt != 4'd0 && cnt != CNT_FULL) begin
                rpt_buf[cnt[2:0]] <= rpt_data;
                cnt               <= cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    if (pending && !take) rpt_drop <= 1'b1;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kbd_hid_decode.sv
// HID boot-report to make/break event stream decoder (diff engine; capture in kbd_hid_rpt_cap).
// Optional build macro KBD_HID_ROLLOVER_FILTER_EN: reports carrying ErrorRollOver are discarded.
module kbd_hid_decode
    import kbd_hid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rpt_data,
    input  logic       rpt_first,
    input  logic       rpt_stb,
    output logic [7:0] evt_data,
    output logic       evt_stb,
    output logic       rpt_drop,
    output logic       rpt_err,
    output logic       busy,
    output eng_state_t dbg_state
);

    // Streams are strobe-only: rpt_stb/evt_stb mark one valid byte per cycle, no ready/backpressure.
    rpt_t       cap_buf;
    rpt_t       old_r;
    rpt_t       new_r;
    logic       pending;
    logic       take;
    logic       skip_rpt;
    eng_state_t state;
    eng_state_t ret_st;
    logic [2:0] idx;
    logic [7:0] brk_code;

    step_t      nxt;
    logic [7:0] cur_code;
    logic       do_brk;
    logic       do_make;

    assign take      = (state == ST_IDLE) && pending;
    assign dbg_state = state;

`ifdef KBD_HID_ROLLOVER_FILTER_EN
    assign skip_rpt = in_slots(cap_buf, KC_ROLLOVER);
`else
    assign skip_rpt = 1'b0;
`endif

    kbd_hid_rpt_cap u_cap (
        .clk      (clk),
        .rst      (rst),
        .rpt_data (rpt_data),
        .rpt_first(rpt_first),
        .rpt_stb  (rpt_stb),
        .take     (take),
        .rpt_buf  (cap_buf),
        .pending  (pending),
        .rpt_drop (rpt_drop),
        .rpt_err  (rpt_err)
    );

    always_comb begin
        nxt      = step_after(state, idx);
        cur_code = KC_NONE;
        do_brk   = 1'b0;
        do_make  = 1'b0;
        case (state)
            ST_MOD: begin
                cur_code = MOD_BASE | {5'd0, idx};
                do_brk   = old_r[0][idx] & ~new_r[0][idx];
                do_make  = ~old_r[0][idx] & new_r[0][idx];
            end
            ST_BRK: begin
                cur_code = slot_code(old_r, idx);
                do_brk   = (cur_code != KC_NONE) && !in_slots(new_r, cur_code)
                           && !dup_below(old_r, idx, cur_code);
            end
            ST_MAKE: begin
                cur_code = slot_code(new_r, idx);
                do_make  = (cur_code != KC_NONE) && !in_slots(old_r, cur_code)
                           && !dup_below(new_r, idx, cur_code);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ret_st   <= ST_IDLE;
            idx      <= 3'd0;
            brk_code <= KC_NONE;
            old_r    <= '0;
            new_r    <= '0;
            evt_data <= 8'h00;
            evt_stb  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            evt_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        new_r <= cap_buf;
                        idx   <= 3'd0;
                        if (skip_rpt) begin
                            busy <= 1'b0;
                        end else begin
                            state <= ST_MOD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_MOD, ST_BRK, ST_MAKE: begin
                    idx <= nxt.idx;
                    if (do_brk) begin
                        // Prefix now, keycode next cycle, then resume at the following step.
                        evt_data <= BRK_PREFIX;
                        evt_stb  <= 1'b1;
                        brk_code <= cur_code;
                        ret_st   <= nxt.st;
                        state    <= ST_BRK_CODE;
                    end else begin
                        if (do_make) begin
                            evt_data <= cur_code;
                            evt_stb  <= 1'b1;
                        end
                        state <= nxt.st;
                    end
                end
                ST_BRK_CODE: begin
                    evt_data <= brk_code;
                    evt_stb  <= 1'b1;
                    state    <= ret_st;
                end
                ST_DONE: begin
                    old_r <= new_r;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
